// File: rtl/nn_mem_pkg.sv
// Shared types and helpers for the NN memory-port arbitration slice.
package nn_mem_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic req_idx_t onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    req_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | req_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module rr_arbiter
  import nn_mem_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  req_idx_t rr_ptr;
  req_idx_t gnt_idx;
  logic     found;

  // First requester at or above rr_ptr, wrapping; nothing granted while in reset.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (rst_n && !found && req[i] && (((32'(rr_ptr) + k) % N) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign gnt_idx = onehot_to_idx(MAX_REQ'(gnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (|gnt) begin
      rr_ptr <= (gnt_idx == req_idx_t'(N - 1)) ? '0 : req_idx_t'(gnt_idx + req_idx_t'(1));
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 1R1W memory between NUM_REQ requesters with independent
// round-robin arbitration on the read and write ports.
module mem_port_arbiter
  import nn_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BIT_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           rd_valid,
  input  logic [NUM_REQ*DEPTH-1:0]     rd_addr,
  output logic [NUM_REQ-1:0]           rd_ready,
  output logic [NUM_REQ-1:0]           rd_rsp_valid,
  output logic [BIT_SIZE-1:0]          rd_rsp_data,
  input  logic [NUM_REQ-1:0]           wr_valid,
  input  logic [NUM_REQ*DEPTH-1:0]     wr_addr,
  input  logic [NUM_REQ*BIT_SIZE-1:0]  wr_data,
  output logic [NUM_REQ-1:0]           wr_ready,
  output logic [DEPTH-1:0]             mem_read_addr,
  output logic                         mem_write_en,
  output logic [DEPTH-1:0]             mem_write_addr,
  output logic [BIT_SIZE-1:0]          mem_data_in,
  input  logic [BIT_SIZE-1:0]          mem_data_out
);

  logic [NUM_REQ-1:0] rd_gnt;
  logic [NUM_REQ-1:0] wr_gnt;
  logic [NUM_REQ-1:0] rsp_sel;

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_valid),
    .gnt   (rd_gnt)
  );

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_valid),
    .gnt   (wr_gnt)
  );

  assign rd_ready = rd_gnt;
  assign wr_ready = wr_gnt;

  // Read address mux: granted slice, zero when idle.
  always_comb begin
    mem_read_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rd_gnt[i]) mem_read_addr = rd_addr[i*DEPTH +: DEPTH];
    end
  end

  // Write mux: granted slice, zero when idle.
  always_comb begin
    mem_write_addr = '0;
    mem_data_in    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        mem_write_addr = wr_addr[i*DEPTH +: DEPTH];
        mem_data_in    = wr_data[i*BIT_SIZE +: BIT_SIZE];
      end
    end
  end

  assign mem_write_en = |(wr_valid & wr_gnt);

  // Remembers who owns the data the memory presents next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sel <= '0;
    end else begin
      rsp_sel <= rd_valid & rd_gnt;
    end
  end

  assign rd_rsp_valid = rsp_sel;
  assign rd_rsp_data  = (|rsp_sel) ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1R1W write-first memory.
module tb_mem_port_arbiter;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned BIT_SIZE = 16;

  logic                        clk;
  logic                        rst_n;
  logic [NUM_REQ-1:0]          rd_valid;
  logic [NUM_REQ*DEPTH-1:0]    rd_addr;
  logic [NUM_REQ-1:0]          rd_ready;
  logic [NUM_REQ-1:0]          rd_rsp_valid;
  logic [BIT_SIZE-1:0]         rd_rsp_data;
  logic [NUM_REQ-1:0]          wr_valid;
  logic [NUM_REQ*DEPTH-1:0]    wr_addr;
  logic [NUM_REQ*BIT_SIZE-1:0] wr_data;
  logic [NUM_REQ-1:0]          wr_ready;
  logic [DEPTH-1:0]            mem_read_addr;
  logic                        mem_write_en;
  logic [DEPTH-1:0]            mem_write_addr;
  logic [BIT_SIZE-1:0]         mem_data_in;
  logic [BIT_SIZE-1:0]         mem_data_out;

  int tests;
  int errs;
  int rsp_cnt [NUM_REQ];

  mem_port_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DEPTH    (DEPTH),
    .BIT_SIZE (BIT_SIZE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_valid       (rd_valid),
    .rd_addr        (rd_addr),
    .rd_ready       (rd_ready),
    .rd_rsp_valid   (rd_rsp_valid),
    .rd_rsp_data    (rd_rsp_data),
    .wr_valid       (wr_valid),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .mem_read_addr  (mem_read_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read address, write lands on the same edge.
  logic [BIT_SIZE-1:0] mem [256];
  logic [DEPTH-1:0]    raddr_q;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    raddr_q = '0;
  end
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_addr] <= mem_data_in;
    raddr_q <= mem_read_addr;
  end
  assign mem_data_out = mem[raddr_q];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    errs  = 0;
    for (int i = 0; i < NUM_REQ; i++) rsp_cnt[i] = 0;
    rst_n    = 1'b0;
    rd_valid = '1;
    wr_valid = '1;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;

    // Held in reset with every request raised: nothing may be granted
    tick();
    tick();
    chk("rst_rd_ready", 32'(rd_ready), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rd_rsp_valid), 32'h0);
    chk("rst_wen", 32'(mem_write_en), 32'h0);
    rd_valid = '0;
    wr_valid = '0;
    rst_n    = 1'b1;
    tick();

    // Reset in the middle of a pending read response
    rd_valid = 4'b0001;
    rd_addr[0*DEPTH +: DEPTH] = 8'h03;
    #1 chk("pre_rd_ready", 32'(rd_ready), 32'h1);
    tick();
    chk("pending_rsp", 32'(rd_rsp_valid), 32'h1);
    rd_valid = 4'b1111;
    rst_n    = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rd_rsp_valid), 32'h0);
    chk("midrst_rd_ready", 32'(rd_ready), 32'h0);
    chk("midrst_rsp_data", 32'(rd_rsp_data), 32'h0);
    tick();
    rst_n = 1'b1;
    #1 chk("post_rst_ptr0", 32'(rd_ready), 32'h1);
    rd_valid = '0;
    tick();

    // Single writer then a reader of the same address
    wr_valid = 4'b0010;
    wr_addr[1*DEPTH +: DEPTH]       = 8'h05;
    wr_data[1*BIT_SIZE +: BIT_SIZE] = 16'h1234;
    #1;
    chk("w1_wr_ready", 32'(wr_ready), 32'h2);
    chk("w1_wen", 32'(mem_write_en), 32'h1);
    chk("w1_waddr", 32'(mem_write_addr), 32'h05);
    chk("w1_wdata", 32'(mem_data_in), 32'h1234);
    tick();
    wr_valid = '0;
    rd_valid = 4'b0100;
    rd_addr[2*DEPTH +: DEPTH] = 8'h05;
    #1;
    chk("r2_rd_ready", 32'(rd_ready), 32'h4);
    chk("r2_raddr", 32'(mem_read_addr), 32'h05);
    chk("idle_wen", 32'(mem_write_en), 32'h0);
    chk("idle_waddr", 32'(mem_write_addr), 32'h0);
    tick();
    rd_valid = '0;
    #1;
    chk("r2_rsp_valid", 32'(rd_rsp_valid), 32'h4);
    chk("r2_rsp_data", 32'(rd_rsp_data), 32'h1234);
    chk("idle_raddr", 32'(mem_read_addr), 32'h0);

    // Wrap: only requester 3 valid, then idle
    rd_valid = 4'b1000;
    rd_addr[3*DEPTH +: DEPTH] = 8'h05;
    #1 chk("wrap_rd_ready", 32'(rd_ready), 32'h8);
    tick();
    rd_valid = '0;
    #1;
    chk("idle_rd_ready", 32'(rd_ready), 32'h0);
    chk("wrap_rsp_valid", 32'(rd_rsp_valid), 32'h8);
    chk("wrap_rsp_data", 32'(rd_rsp_data), 32'h1234);
    tick();
    chk("idle_rsp_valid", 32'(rd_rsp_valid), 32'h0);
    chk("idle_rsp_data", 32'(rd_rsp_data), 32'h0);

    // Write contention; write pointer sits at 2 after the earlier grant to 1
    wr_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wr_addr[i*DEPTH +: DEPTH]       = DEPTH'(8'h20 + i);
      wr_data[i*BIT_SIZE +: BIT_SIZE] = BIT_SIZE'(16'hA000 + i);
    end
    for (int c = 0; c < 4; c++) begin
      int g;
      g = (c + 2) % 4;
      #1;
      chk("wcont_ready", 32'(wr_ready), 32'(1 << g));
      chk("wcont_waddr", 32'(mem_write_addr), 32'(8'h20 + g));
      tick();
      wr_valid[g] = 1'b0;
    end

    // Read contention for 8 cycles; pointer at 0 after the wrap test
    rd_valid = 4'b1111;
    for (int i = 0; i < 4; i++) rd_addr[i*DEPTH +: DEPTH] = DEPTH'(8'h20 + i);
    for (int c = 0; c <= 8; c++) begin
      if (c == 8) rd_valid = '0;
      #1;
      if (c < 8) chk("rcont_ready", 32'(rd_ready), 32'(1 << (c % 4)));
      if (c > 0) begin
        chk("rcont_rsp_valid", 32'(rd_rsp_valid), 32'(1 << ((c - 1) % 4)));
        chk("rcont_rsp_data", 32'(rd_rsp_data), 32'(16'hA000 + ((c - 1) % 4)));
      end
      for (int i = 0; i < NUM_REQ; i++) if (rd_rsp_valid[i]) rsp_cnt[i]++;
      tick();
    end
    for (int i = 0; i < NUM_REQ; i++) chk("rcont_count", 32'(rsp_cnt[i]), 32'd2);

    // Same-cycle write and read of one address returns the new data
    wr_valid = 4'b0001;
    wr_addr[0*DEPTH +: DEPTH]       = 8'h10;
    wr_data[0*BIT_SIZE +: BIT_SIZE] = 16'hBEEF;
    rd_valid = 4'b0010;
    rd_addr[1*DEPTH +: DEPTH] = 8'h10;
    #1;
    chk("coll_wr_ready", 32'(wr_ready), 32'h1);
    chk("coll_rd_ready", 32'(rd_ready), 32'h2);
    tick();
    wr_valid = '0;
    rd_valid = '0;
    #1;
    chk("coll_rsp_valid", 32'(rd_rsp_valid), 32'h2);
    chk("coll_rsp_data", 32'(rd_rsp_data), 32'hBEEF);

    // One requester reading and writing different addresses together
    rd_valid = 4'b0001;
    rd_addr[0*DEPTH +: DEPTH] = 8'h20;
    wr_valid = 4'b0001;
    wr_addr[0*DEPTH +: DEPTH]       = 8'h30;
    wr_data[0*BIT_SIZE +: BIT_SIZE] = 16'h5A5A;
    #1;
    chk("conc_rd_ready", 32'(rd_ready), 32'h1);
    chk("conc_wr_ready", 32'(wr_ready), 32'h1);
    chk("conc_wen", 32'(mem_write_en), 32'h1);
    tick();
    wr_valid = '0;
    rd_addr[0*DEPTH +: DEPTH] = 8'h30;
    #1;
    chk("conc_rsp_valid", 32'(rd_rsp_valid), 32'h1);
    chk("conc_rsp_data", 32'(rd_rsp_data), 32'hA000);
    tick();
    rd_valid = '0;
    #1;
    chk("conc_wrchk_data", 32'(rd_rsp_data), 32'h5A5A);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
